lz_match_search: RTL and testbench
==================================

# lz_match_search

Parametrised, sequential LZ77 longest-match engine: the next generation of the 8-byte single-shot comparator. It latches a search window and a lookahead buffer, then scans every candidate start position, one per clock. It reports the longest prefix match between the lookahead and the window, including matches that overlap into the lookahead. It sits between the window/lookahead buffer manager and the token encoder in the compression datapath.

## Interface
- `SYMW`, 8, bits per symbol
- `SB_LEN`, 9, search-buffer depth in symbols (≥2)
- `LA_LEN`, 8, lookahead depth in symbols (≥1)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a search; accepted only in IDLE
- `sb_data`  in  SB_LEN*SYMW  search symbols; symbol j (0 = oldest) at `[SYMW*j +: SYMW]`
- `la_data`  in  LA_LEN*SYMW  lookahead symbols; symbol i (0 = next to encode) at `[SYMW*i +: SYMW]`
- `la_valid`  in  $clog2(LA_LEN+1)  number of valid lookahead symbols
- `busy`  out  1  high in SCAN and DONE
- `done`  out  1  one-cycle pulse; results valid
- `match_len`  out  $clog2(LA_LEN+1)  best match length
- `match_off`  out  $clog2(SB_LEN)  start position j of the best match (distance = SB_LEN − match_off)

## Operation
- Combined window W: W[j] = sb symbol j for j < SB_LEN, and W[j] = la symbol (j−SB_LEN) otherwise. The lookahead is always sourced from latched copies.
- Length at position o is the count of consecutive i from 0 with la[i] == W[o+i], for i < L.
  - L = min(la_valid, LA_LEN). Values of `la_valid` above LA_LEN are clamped.
  - Never indexes W beyond SB_LEN+LA_LEN−1.
- FSM states:
  - IDLE: on `start`, latch `sb_data`, `la_data` and clamped L. Clear best_len and best_off. Set o=0 and go to SCAN.
  - SCAN: evaluate position o. If the length is strictly greater than best_len, update best_len and best_off=o.
    - If o == SB_LEN−1, go to DONE.
    - Otherwise increment o.
  - DONE: drive `done`=1, copy best values to `match_len`/`match_off`, return to IDLE.
- Ties resolve to the lowest position, because replacement requires strictly greater length.
- No match: `match_len`=0, `match_off`=0.
- `start` is ignored while busy. Input changes after the latch have no effect.
- `match_len`/`match_off` hold their value until the next DONE.
- `reset` in any state: go to IDLE and drive all outputs to 0. A search in progress is abandoned and no `done` is emitted.

## Timing
- Reset values: `busy`=0, `done`=0, `match_len`=0, `match_off`=0.
- `start` sampled high at edge 0 → SCAN during cycles 1..SB_LEN → `done` high in cycle SB_LEN+1.
  - Default latency is 10 cycles.
- `busy` rises at cycle 1 and falls after the `done` cycle.
- A new `start` may be accepted in the cycle after `done`.
- Per-position compare is fully combinational within one cycle: LA_LEN symbol comparators plus a leading-match count.

## Configuration
- `LZ_EARLY_EXIT_EN` defined: after evaluating position o, if best_len == L, go directly to DONE.
  - Latency becomes o+2.
  - L=0 finishes with `done` at cycle 2, with len 0 and off 0.
- Undefined: every search scans all SB_LEN positions, giving a fixed latency of SB_LEN+1.
- Results (len, off) are identical in both builds.

## Test plan
All tests use defaults SYMW=8, SB_LEN=9, LA_LEN=8.
- Basic match: sb="ABCDEFGHI" (j0='A'), la="CDEFXYZW", la_valid=8, start → `done` at cycle 10, len=4, off=2.
- Overlap match: sb=0x00 ×8 with sb[8]=0x61, la=0x61 ×8, la_valid=8 → len=8, off=8, in both builds.
- Tie and early exit, sb="ABABABABA" with la="AB" (rest 0x00):
  - la_valid=3 → len=2, off=0, done at cycle 10.
  - la_valid=2 → len=2, off=0; done at cycle 2 with `LZ_EARLY_EXIT_EN`, cycle 10 without.
- No match and clamp:
  - sb all 0x00, la all 0xFF, la_valid=8 → len=0, off=0.
  - la_valid=12 with the basic-match data → len=4, off=2.
- Reset and busy:
  - Assert `reset` at cycle 4 of a scan → no `done`, all outputs 0, `busy`=0 next cycle.
  - `start` pulsed during SCAN → ignored; the original results are unaffected.

Source files
------------

// File: rtl/lz_match_search.sv
// lz_match_search -- sequential LZ77 longest-match engine.
//
// Latches a search window (sb_data) and a lookahead buffer (la_data). Then it
// evaluates one candidate start position per clock over the combined window
// W = {lookahead, search}. Because of this, matches may run from the search
// buffer into the lookahead. The longest prefix match wins. On a tie the
// lowest start position wins.
//
// Build option:
//   LZ_EARLY_EXIT_EN  when defined, the scan stops as soon as a match covers
//                     the full clamped lookahead length L. Results are the
//                     same either way; only the latency changes.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request a search (accepted only when idle)
//   sb_data    search symbols, symbol j (0 = oldest) at [SYMW*j +: SYMW]
//   la_data    lookahead symbols, symbol i (0 = next) at [SYMW*i +: SYMW]
//   la_valid   number of valid lookahead symbols (clamped to LA_LEN)
//   busy       high while scanning and during the done cycle
//   done       one-cycle pulse, match_len/match_off valid
//   match_len  best match length (0 = no match)
//   match_off  start position j of the best match (distance = SB_LEN - j)

module lz_match_search #(
   parameter  int SYMW   = 8,
   parameter  int SB_LEN = 9,
   parameter  int LA_LEN = 8,
   localparam int LW     = $clog2(LA_LEN + 1),
   localparam int OW     = $clog2(SB_LEN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [SB_LEN*SYMW-1:0]   sb_data,
   input  logic [LA_LEN*SYMW-1:0]   la_data,
   input  logic [LW-1:0]            la_valid,
   output logic                     busy,
   output logic                     done,
   output logic [LW-1:0]            match_len,
   output logic [OW-1:0]            match_off
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [SB_LEN*SYMW-1:0]   sb_q, sb_d;
   logic [LA_LEN*SYMW-1:0]   la_q, la_d;
   logic [LW-1:0]            l_q, l_d;
   logic [OW-1:0]            o_q, o_d;
   logic [LW-1:0]            best_len_q, best_len_d;
   logic [OW-1:0]            best_off_q, best_off_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [LW-1:0]            match_len_q, match_len_d;
   logic [OW-1:0]            match_off_q, match_off_d;

   logic                     load;
   logic                     last;
   logic [LW-1:0]            cur_len;
   logic                     run;
   logic [(SB_LEN+LA_LEN)*SYMW-1:0] win;

   // Match length at position o_q. la[i] is compared with W[o+i] for i < L,
   // and the count stops at the first mismatch. The highest index touched is
   // (SB_LEN-1)+(LA_LEN-1), which stays inside W.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch
      // is inferred; blocking '=' is correct inside combinational blocks.
      win     = {la_q, sb_q};
      cur_len = '0;
      run     = 1'b1;
      for (int i = 0; i < LA_LEN; i++) begin
         if (run && (i < int'(l_q)) &&
             (la_q[SYMW*i +: SYMW] == win[SYMW*(int'(o_q) + i) +: SYMW])) begin
            cur_len = cur_len + LW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Next-state logic for the FSM and the registered outputs.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      o_d         = o_q;
      best_len_d  = best_len_q;
      best_off_d  = best_off_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      match_len_d = match_len_q;
      match_off_d = match_off_q;
      load        = 1'b0;
      last        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               load       = 1'b1;
               l_d        = (la_valid > LW'(LA_LEN)) ? LW'(LA_LEN) : la_valid;
               best_len_d = '0;
               best_off_d = '0;
               o_d        = '0;
               busy_d     = 1'b1;
               state_d    = S_SCAN;
            end
         end

         S_SCAN: begin
            // Strictly greater: on a tie the earlier (lower) position is kept.
            if (cur_len > best_len_q) begin
               best_len_d = cur_len;
               best_off_d = o_q;
            end
            last = (o_q == OW'(SB_LEN - 1));
`ifdef LZ_EARLY_EXIT_EN
            // Nothing can beat a match that already covers the whole lookahead.
            if (best_len_d == l_q) begin
               last = 1'b1;
            end
`endif
            if (last) begin
               // The results are published on entry to DONE, so they are
               // valid in the same cycle as the done pulse.
               done_d      = 1'b1;
               match_len_d = best_len_d;
               match_off_d = best_off_d;
               state_d     = S_DONE;
            end else begin
               o_d = o_q + OW'(1);
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Symbol copies only change when a search is accepted.
   always_comb begin
      sb_d = load ? sb_data : sb_q;
      la_d = load ? la_data : la_q;
   end

   // NOTE: the latched symbol buffers have no reset. They are always written
   // on start before they are read, so resetting them would only add fan-out.
   always_ff @(posedge clk) begin
      sb_q <= sb_d;
      la_q <= la_d;
   end

   // NOTE: sequential state uses non-blocking '<=' so that every flop samples
   // the values from before the edge, whatever order the statements are in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         l_q         <= '0;
         o_q         <= '0;
         best_len_q  <= '0;
         best_off_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         match_len_q <= '0;
         match_off_q <= '0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         o_q         <= o_d;
         best_len_q  <= best_len_d;
         best_off_q  <= best_off_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         match_len_q <= match_len_d;
         match_off_q <= match_off_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign match_len = match_len_q;
   assign match_off = match_off_q;

endmodule

// File: tb/tb_lz_match_search.sv
// Testbench for lz_match_search with the default parameters (SYMW=8, SB_LEN=9,
// LA_LEN=8). Directed vectors come from a table. Hand-written sequences cover
// reset during a scan and a start pulse during a scan. The expected latencies
// follow the LZ_EARLY_EXIT_EN build option.

module tb_lz_match_search;

   localparam int SYMW   = 8;
   localparam int SB_LEN = 9;
   localparam int LA_LEN = 8;
   localparam int LW     = $clog2(LA_LEN + 1);
   localparam int OW     = $clog2(SB_LEN);
   localparam int MAXLAT = 40;

`ifdef LZ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic [SB_LEN*SYMW-1:0] sb_data;
   logic [LA_LEN*SYMW-1:0] la_data;
   logic [LW-1:0]          la_valid;
   logic                   busy;
   logic                   done;
   logic [LW-1:0]          match_len;
   logic [OW-1:0]          match_off;

   lz_match_search #(.SYMW(SYMW), .SB_LEN(SB_LEN), .LA_LEN(LA_LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sb_data   (sb_data),
      .la_data   (la_data),
      .la_valid  (la_valid),
      .busy      (busy),
      .done      (done),
      .match_len (match_len),
      .match_off (match_off)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Character 0 of the string goes to symbol 0 (lowest bits).
   function automatic logic [SB_LEN*SYMW-1:0] mk_sb(input string s);
      logic [SB_LEN*SYMW-1:0] r;
      r = '0;
      for (int j = 0; j < s.len() && j < SB_LEN; j++) r[SYMW*j +: SYMW] = s[j];
      return r;
   endfunction

   function automatic logic [LA_LEN*SYMW-1:0] mk_la(input string s);
      logic [LA_LEN*SYMW-1:0] r;
      r = '0;
      for (int i = 0; i < s.len() && i < LA_LEN; i++) r[SYMW*i +: SYMW] = s[i];
      return r;
   endfunction

   typedef struct {
      logic [SB_LEN*SYMW-1:0] sb;
      logic [LA_LEN*SYMW-1:0] la;
      logic [LW-1:0]          lv;
      int                     len;
      int                     off;
      int                     lat;
   } vec_t;

   vec_t vecs[7];

   // One search: start is sampled at edge 0, and cycle n is the period after
   // edge n-1. The inputs are scrambled after the latch to show that they are
   // ignored from then on.
   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      sb_data  = v.sb;
      la_data  = v.la;
      la_valid = v.lv;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      sb_data  = ~v.sb;
      la_data  = ~v.la;
      la_valid = LW'(1);
      lat = 1;
      check($sformatf("v%0d busy_c1", idx), busy, 1);
      while (done !== 1'b1 && lat < MAXLAT) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", idx), lat, v.lat);
      check($sformatf("v%0d len", idx), match_len, v.len);
      check($sformatf("v%0d off", idx), match_off, v.off);
      @(posedge clk); #1;
      check($sformatf("v%0d busy_after", idx), busy, 0);
      check($sformatf("v%0d done_after", idx), done, 0);
      check($sformatf("v%0d len_hold", idx), match_len, v.len);
      check($sformatf("v%0d off_hold", idx), match_off, v.off);
   endtask

   initial begin
      logic [SB_LEN*SYMW-1:0] basic_sb, ab_sb, ovl_sb;
      logic [LA_LEN*SYMW-1:0] basic_la, ab_la, ovl_la;
      int lat;
      int n_done;

      basic_sb = mk_sb("ABCDEFGHI");
      basic_la = mk_la("CDEFXYZW");
      ab_sb    = mk_sb("ABABABABA");
      ab_la    = mk_la("AB");
      ovl_sb   = '0;
      ovl_sb[SYMW*8 +: SYMW] = 8'h61;
      ovl_la   = {LA_LEN{8'h61}};

      vecs[0] = '{basic_sb, basic_la,      LW'(8),  4, 2, 10};
      vecs[1] = '{ovl_sb,   ovl_la,        LW'(8),  8, 8, 10};
      vecs[2] = '{ab_sb,    ab_la,         LW'(3),  2, 0, 10};
      vecs[3] = '{ab_sb,    ab_la,         LW'(2),  2, 0, EARLY ? 2 : 10};
      vecs[4] = '{'0,       {LA_LEN{8'hFF}}, LW'(8), 0, 0, 10};
      vecs[5] = '{ab_sb,    ab_la,         LW'(0),  0, 0, EARLY ? 2 : 10};
      vecs[6] = '{basic_sb, basic_la,      LW'(12), 4, 2, 10};

      reset    = 1'b1;
      start    = 1'b0;
      sb_data  = '0;
      la_data  = '0;
      la_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst len", match_len, 0);
      check("rst off", match_off, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Back-to-back: each search starts in the cycle after the previous done.
      for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

      // Reset in cycle 4 of a scan: the search is abandoned and all outputs
      // clear, including the results of the previous search.
      sb_data  = basic_sb;
      la_data  = basic_la;
      la_valid = LW'(8);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst len", match_len, 0);
      check("midrst off", match_off, 0);
      n_done = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done === 1'b1) n_done++;
      end
      check("midrst no_done", n_done, 0);

      // A start pulse in the middle of a scan, with different data, is ignored.
      sb_data  = basic_sb;
      la_data  = basic_la;
      la_valid = LW'(8);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < MAXLAT) begin
         if (lat == 3) begin
            start   = 1'b1;
            sb_data = ovl_sb;
            la_data = ovl_la;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("ign latency", lat, 10);
      check("ign len", match_len, 4);
      check("ign off", match_off, 2);
      n_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1) n_done++;
      end
      check("ign no_second_done", n_done, 0);
      check("ign len_hold", match_len, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
